// File: rtl/sipo_pkg.sv
// Shared definitions for the SIPO deserializer: bit-order encoding,
// bit-counter sizing and the even-parity helper.
// Optional feature macro: SIPO_PARITY_EN (trailing even-parity bit per frame).
package sipo_pkg;

    // Order in which serial bits are placed into the word.
    typedef enum logic {
        ORDER_MSB = 1'b0,
        ORDER_LSB = 1'b1
    } order_e;

    // Widest word supported; the parity helper works on this width.
    localparam int MAX_WIDTH = 64;

    // Bits needed to count from 0 up to and including width.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    // XOR reduction: 1 when the vector holds an odd number of ones.
    function automatic logic even_parity(input logic [MAX_WIDTH-1:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/sipo_out_buffer.sv
// Output holding register for the deserializer: stores one completed word,
// presents it with valid/ready, and flags a sticky overrun when a word
// arrives while the previous one is still unconsumed.
module sipo_out_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_overrun
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_overrun;

    // Load, consume or drop a word; a load on the consume edge keeps valid high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (i_clear) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (i_load) begin
            if (!r_valid || i_ready) begin
                r_data  <= i_data;
                r_valid <= 1'b1;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/sipo_deserializer.sv
// Parametrised serial-in/parallel-out deserializer. Keeps the shift register,
// bit counter and per-word bit-order latch; completed words go to
// sipo_out_buffer for the valid/ready handshake.
// Optional feature macro: SIPO_PARITY_EN -- each frame carries one trailing
// even-parity bit that is checked and reported on parity_err.
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int  WIDTH = 8,
    localparam int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             serial_in,
    input  logic             shift,
    input  logic             lsb_first,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic [CNT_W-1:0] bit_count,
    output logic             overrun
`ifdef SIPO_PARITY_EN
    ,
    output logic             parity_err
`endif
);

`ifdef SIPO_PARITY_EN
    // Frame = data bits + parity bit; the buffer also carries the parity flag.
    localparam int FRAME = WIDTH + 1;
    localparam int BUF_W = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
    localparam int BUF_W = WIDTH;
`endif

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME - 1);

    logic [WIDTH-1:0] r_shift_reg;
    logic [CNT_W-1:0] r_bit_count;
    order_e           r_order;

    logic             w_first;
    logic             w_last;
    logic             w_data_bit;
    logic             w_complete;
    order_e           w_order;
    logic [WIDTH-1:0] w_shift_next;
    logic [BUF_W-1:0] w_word;
    logic [BUF_W-1:0] w_buf_data;

    assign w_first    = (r_bit_count == '0);
    assign w_last     = (r_bit_count == LAST_IDX);
    assign w_complete = shift && w_last;

    // First bit of a word takes the live order input; later bits use the latch.
    assign w_order = w_first ? order_e'(lsb_first) : r_order;

    // Next shift-register contents for the selected bit order.
    always_comb begin
        w_shift_next = r_shift_reg;
        if (w_order == ORDER_LSB) begin
            w_shift_next = {serial_in, r_shift_reg[WIDTH-1:1]};
        end else begin
            w_shift_next = {r_shift_reg[WIDTH-2:0], serial_in};
        end
    end

`ifdef SIPO_PARITY_EN
    // Parity bit arrives last and is checked, never stored in the word.
    assign w_data_bit = !w_last;
    assign w_word     = {even_parity(MAX_WIDTH'(r_shift_reg)) ^ serial_in, r_shift_reg};
`else
    // Last data bit is folded in combinationally so the word loads on this edge.
    assign w_data_bit = 1'b1;
    assign w_word     = w_shift_next;
`endif

    // Capture serial bits, latch the order on the first bit, wrap the counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift_reg <= '0;
            r_bit_count <= '0;
            r_order     <= ORDER_MSB;
        end else if (clear) begin
            r_shift_reg <= '0;
            r_bit_count <= '0;
            r_order     <= ORDER_MSB;
        end else if (shift) begin
            if (w_data_bit) begin
                r_shift_reg <= w_shift_next;
            end
            if (w_first) begin
                r_order <= order_e'(lsb_first);
            end
            r_bit_count <= w_last ? '0 : r_bit_count + CNT_W'(1);
        end
    end

    sipo_out_buffer #(
        .WIDTH (BUF_W)
    ) u_out_buffer (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clear   (clear),
        .i_load    (w_complete),
        .i_data    (w_word),
        .i_ready   (data_ready),
        .o_data    (w_buf_data),
        .o_valid   (data_valid),
        .o_overrun (overrun)
    );

`ifdef SIPO_PARITY_EN
    assign data_out   = w_buf_data[WIDTH-1:0];
    assign parity_err = w_buf_data[WIDTH];
`else
    assign data_out   = w_buf_data;
`endif

    assign bit_count = r_bit_count;

endmodule
